// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: circular buffer of instruction/PC pairs with
// valid/ready on both sides, head opcode decode, redirect flush and delivery stats.
module instr_fetch_queue #(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 32,
  parameter int DEPTH       = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_WIDTH-1:0]     in_instr,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_WIDTH-1:0]     out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [1:0]                 out_class,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_WIDTH-1:0]       pop_cnt,
  output logic [CNT_WIDTH-1:0]       illegal_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int EW    = INSTR_WIDTH + PC_WIDTH;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic [EW-1:0]        mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CW-1:0]        count_q;
  logic [CNT_WIDTH-1:0] pop_cnt_q;
  logic [CNT_WIDTH-1:0] illegal_cnt_q;
  logic [EW-1:0]        head;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Every output is forced low while reset is held, even before the first reset edge.
  assign in_ready  = !rst && !full;
  assign out_valid = !rst && !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head      = mem[rd_ptr];
  assign out_instr = out_valid ? head[EW-1:PC_WIDTH] : '0;
  assign out_pc    = out_valid ? head[PC_WIDTH-1:0]  : '0;

  assign count       = rst ? '0 : count_q;
  assign pop_cnt     = rst ? '0 : pop_cnt_q;
  assign illegal_cnt = rst ? '0 : illegal_cnt_q;

  always_comb begin
    out_class   = 2'd0;
    out_illegal = 1'b0;
    if (out_valid) begin
      case (out_instr[6:0])
        OP_ADDI: out_class = 2'd0;
        OP_ADD:  out_class = 2'd1;
        OP_BEQ:  out_class = 2'd2;
        OP_JAL:  out_class = 2'd3;
        default: out_illegal = 1'b1;
      endcase
    end
  end

  // Storage is deliberately left unreset; a push that collides with a flush is dropped.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= {in_instr, in_pc};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count_q       <= '0;
      pop_cnt_q     <= '0;
      illegal_cnt_q <= '0;
    end else begin
      if (flush) begin
        rd_ptr  <= wr_ptr;
        count_q <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count_q <= count_q + CW'(1);
        else if (pop && !push) count_q <= count_q - CW'(1);
      end
      // A pop in a flush cycle was still consumed by the core, so it is counted.
      if (pop && (pop_cnt_q != '1)) begin
        pop_cnt_q <= pop_cnt_q + CNT_WIDTH'(1);
      end
      if (pop && out_illegal && (illegal_cnt_q != '1)) begin
        illegal_cnt_q <= illegal_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

endmodule
